// File: rtl/flux_pkg.sv
// flux_pkg: helpers shared by flux_demux_sink and the upstream wrappers that
// build tokens for it.
//   tag_width()     - bits needed to name FLUX streams, never less than 1
//   token_tag()     - tag field of a token (the top tag_w bits)
//   token_payload() - payload field of a token (the low data_w bits)
// Tokens are passed zero-extended to MAX_TOKEN_W bits, so one pair of helpers
// serves every token width up to 64.
package flux_pkg;

    localparam int unsigned MAX_TOKEN_W = 64;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_TOKEN_W-1:0] token_tag(
        input logic [MAX_TOKEN_W-1:0] tok,
        input int unsigned            width,
        input int unsigned            tag_w
    );
        logic [MAX_TOKEN_W-1:0] mask;
        mask = (MAX_TOKEN_W'(1) << tag_w) - MAX_TOKEN_W'(1);
        return (tok >> (width - tag_w)) & mask;
    endfunction

    function automatic logic [MAX_TOKEN_W-1:0] token_payload(
        input logic [MAX_TOKEN_W-1:0] tok,
        input int unsigned            data_w
    );
        logic [MAX_TOKEN_W-1:0] mask;
        mask = (MAX_TOKEN_W'(1) << data_w) - MAX_TOKEN_W'(1);
        return tok & mask;
    endfunction

endpackage

// File: rtl/flux_fifo.sv
// flux_fifo: first-word-fall-through FIFO, one per flux.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push/din : write strobe and payload, ignored when full
//   pop      : read strobe, ignored when empty
//   dout     : head entry, valid whenever empty=0
//   empty    : count==0,  full : count==DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module flux_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/flux_demux_sink.sv
// flux_demux_sink: splits one tagged token stream into FLUX FWFT FIFOs.
//   clk, rst          : clock, asynchronous active-high reset
//   in_port_write     : upstream token strobe
//   in_port_datain    : {tag, payload}
//   in_port_full      : stall upstream while any flux FIFO is full
//   out_port_read     : per-flux pop strobes
//   out_port_dataout  : per-flux head payloads, flux f at [f*DATA_WIDTH +: DATA_WIDTH]
//   out_port_empty    : per-flux empty flags
// Optional (macro FLUX_DEMUX_STATS_EN):
//   stat_count        : per-flux accepted-token counters, 16 bits each, saturating
//   stat_drop         : count of tokens dropped for an out-of-range tag, saturating
module flux_demux_sink
    import flux_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int FLUX  = 2,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_port_write,
    input  logic [WIDTH-1:0]                 in_port_datain,
    output logic                             in_port_full,
    input  logic [FLUX-1:0]                  out_port_read,
    output logic [FLUX*(WIDTH-tag_width(FLUX))-1:0] out_port_dataout,
    output logic [FLUX-1:0]                  out_port_empty
`ifdef FLUX_DEMUX_STATS_EN
    ,
    output logic [FLUX*16-1:0]               stat_count,
    output logic [15:0]                      stat_drop
`endif
);
    localparam int TAG_WIDTH  = tag_width(FLUX);
    localparam int DATA_WIDTH = WIDTH - TAG_WIDTH;

    logic [MAX_TOKEN_W-1:0] token_ext;
    logic [TAG_WIDTH-1:0]   tag;
    logic [DATA_WIDTH-1:0]  payload;
    logic                   accept, tag_ok;
    logic [FLUX-1:0]        push_vec, full_vec;

    assign token_ext = MAX_TOKEN_W'(in_port_datain);
    assign tag       = TAG_WIDTH'(token_tag(token_ext, WIDTH, TAG_WIDTH));
    assign payload   = DATA_WIDTH'(token_payload(token_ext, DATA_WIDTH));

    // Upstream cannot know the next tag, so any full FIFO stalls the whole port.
    assign in_port_full = |full_vec;
    assign accept       = in_port_write & ~in_port_full;
    assign tag_ok       = (int'(tag) < FLUX);

    genvar g;
    generate
        for (g = 0; g < FLUX; g++) begin : g_flux
            assign push_vec[g] = accept & tag_ok & (int'(tag) == g);

            flux_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push_vec[g]),
                .pop   (out_port_read[g]),
                .din   (payload),
                .dout  (out_port_dataout[g*DATA_WIDTH +: DATA_WIDTH]),
                .empty (out_port_empty[g]),
                .full  (full_vec[g])
            );

`ifdef FLUX_DEMUX_STATS_EN
            logic [15:0] cnt_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                               cnt_q <= '0;
                else if (push_vec[g] && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
            end
            assign stat_count[g*16 +: 16] = cnt_q;
`endif
        end
    endgenerate

`ifdef FLUX_DEMUX_STATS_EN
    logic [15:0] drop_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  drop_q <= '0;
        else if (accept && !tag_ok && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
    assign stat_drop = drop_q;
`endif

endmodule

// File: tb/tb_flux_demux_sink.sv
// Bench for flux_demux_sink (WIDTH=9, FLUX=2, DEPTH=4): vector table, corner
// sequences, then random traffic against a queue-per-flux reference model.
// Under FLUX_DEMUX_STATS_EN a FLUX=3 instance exercises the counters.
module tb_flux_demux_sink;
    localparam int WIDTH = 9;
    localparam int FLUX  = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wr  = 1'b0;
    logic [WIDTH-1:0]    din = '0;
    logic [FLUX-1:0]     rd  = '0;
    wire                 full;
    wire [FLUX*DW-1:0]   dout;
    wire [FLUX-1:0]      empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef FLUX_DEMUX_STATS_EN
    wire [FLUX*16-1:0] stat_count;
    wire [15:0]        stat_drop;
    logic              wr3  = 1'b0;
    logic [9:0]        din3 = '0;
    logic [2:0]        rd3  = '0;
    wire               full3;
    wire [23:0]        dout3;
    wire [2:0]         empty3;
    wire [47:0]        sc3;
    wire [15:0]        sd3;

    flux_demux_sink #(.WIDTH(10), .FLUX(3), .DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_port_write(wr3), .in_port_datain(din3),
        .in_port_full(full3), .out_port_read(rd3), .out_port_dataout(dout3),
        .out_port_empty(empty3), .stat_count(sc3), .stat_drop(sd3)
    );
`endif

    flux_demux_sink #(.WIDTH(WIDTH), .FLUX(FLUX), .DEPTH(DEPTH)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .in_port_write    (wr),
        .in_port_datain   (din),
        .in_port_full     (full),
        .out_port_read    (rd),
        .out_port_dataout (dout),
        .out_port_empty   (empty)
`ifdef FLUX_DEMUX_STATS_EN
        ,
        .stat_count       (stat_count),
        .stat_drop        (stat_drop)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic push_tok(input logic tag, input logic [7:0] data);
        wr = 1'b1; din = {tag, data};
        step();
        wr = 1'b0;
    endtask

    task automatic pop_flux(input int f);
        rd = '0; rd[f] = 1'b1;
        step();
        rd = '0;
    endtask

    function automatic logic [7:0] d_of(input int f);
        return dout[f*DW +: DW];
    endfunction

    typedef struct {
        logic            wr;
        logic [WIDTH-1:0] din;
        logic [1:0]      rd;
        logic [1:0]      e_empty;
        logic            e_full;
        logic [7:0]      e_d0;
        logic [7:0]      e_d1;
    } vec_t;

    vec_t tbl[8];

    logic [7:0] mq [FLUX][$];
    int         acc_cnt [FLUX];

    initial begin
        // Table rows: inputs applied for one edge, expectations seen after it.
        tbl[0] = '{1'b1, {1'b1, 8'h08}, 2'b00, 2'b01, 1'b0, 8'h00, 8'h08};
        tbl[1] = '{1'b1, {1'b0, 8'h11}, 2'b00, 2'b00, 1'b0, 8'h11, 8'h08};
        tbl[2] = '{1'b1, {1'b0, 8'h22}, 2'b10, 2'b10, 1'b0, 8'h11, 8'h00};
        tbl[3] = '{1'b0, {1'b0, 8'h00}, 2'b01, 2'b10, 1'b0, 8'h22, 8'h00};
        tbl[4] = '{1'b0, {1'b0, 8'h00}, 2'b11, 2'b11, 1'b0, 8'h00, 8'h00};
        tbl[5] = '{1'b1, {1'b1, 8'h33}, 2'b10, 2'b01, 1'b0, 8'h00, 8'h33};
        tbl[6] = '{1'b1, {1'b1, 8'h44}, 2'b10, 2'b01, 1'b0, 8'h00, 8'h44};
        tbl[7] = '{1'b0, {1'b0, 8'h00}, 2'b10, 2'b11, 1'b0, 8'h00, 8'h00};

        // Reset state, including across a clock edge with a write pending.
        #1;
        chk("reset_empty", 32'(empty), 32'h3);
        chk("reset_full", 32'(full), 32'h0);
        wr = 1'b1; din = {1'b0, 8'hAA}; rd = 2'b11;
        step();
        chk("reset_hold_empty", 32'(empty), 32'h3);
        wr = 1'b0; rd = '0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wr = tbl[i].wr; din = tbl[i].din; rd = tbl[i].rd;
            step();
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            if (!tbl[i].e_empty[0]) chk($sformatf("vec%0d_d0", i), 32'(d_of(0)), 32'(tbl[i].e_d0));
            if (!tbl[i].e_empty[1]) chk($sformatf("vec%0d_d1", i), 32'(d_of(1)), 32'(tbl[i].e_d1));
        end
        wr = 1'b0; rd = '0;

        // Fill flux0, overflow write ignored, drain in order.
        do_reset();
        for (int i = 1; i <= 4; i++) push_tok(1'b0, 8'(i));
        chk("fill_full", 32'(full), 32'h1);
        wr = 1'b1; din = {1'b0, 8'd5};
        step();
        wr = 1'b0;
        chk("overflow_full", 32'(full), 32'h1);
        chk("overflow_e1", 32'(empty[1]), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(d_of(0)), 32'(i));
            pop_flux(0);
            chk($sformatf("drain%0d_full", i), 32'(full), 32'h0);
        end
        chk("drain_empty", 32'(empty), 32'h3);

        // Simultaneous push and pop on a flux holding two tokens.
        do_reset();
        push_tok(1'b0, 8'hA1);
        push_tok(1'b0, 8'hA2);
        wr = 1'b1; din = {1'b0, 8'hA3}; rd = 2'b01;
        step();
        wr = 1'b0; rd = '0;
        chk("pp_head", 32'(d_of(0)), 32'hA2);
        chk("pp_empty", 32'(empty), 32'h2);
        pop_flux(0);
        chk("pp_next", 32'(d_of(0)), 32'hA3);
        pop_flux(0);
        chk("pp_count2", 32'(empty[0]), 32'h1);

        // Reads on empty fluxes must not move pointers.
        do_reset();
        rd = 2'b11;
        step();
        step();
        rd = '0;
        chk("rdempty_empty", 32'(empty), 32'h3);
        push_tok(1'b0, 8'h5A);
        chk("rdempty_head", 32'(d_of(0)), 32'h5A);
        push_tok(1'b0, 8'h5B);
        pop_flux(0);
        chk("rdempty_next", 32'(d_of(0)), 32'h5B);

        // Asynchronous reset mid-operation with flux0 full.
        do_reset();
        for (int i = 0; i < 4; i++) push_tok(1'b0, 8'(8'h70 + i));
        push_tok(1'b1, 8'h7F);
        chk("pre_rst_full", 32'(full), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_empty", 32'(empty), 32'h3);
        chk("async_rst_full", 32'(full), 32'h0);
        wr = 1'b1; din = {1'b0, 8'h77}; rd = 2'b11;
        step();
        chk("rst_held_empty", 32'(empty), 32'h3);
        wr = 1'b0; rd = '0; rst = 1'b0;
        push_tok(1'b1, 8'h08);
        chk("post_rst_empty", 32'(empty), 32'h1);
        chk("post_rst_d1", 32'(d_of(1)), 32'h08);

        // Random traffic against the queue model.
        do_reset();
        for (int f = 0; f < FLUX; f++) acc_cnt[f] = 0;
        for (int n = 0; n < 3000; n++) begin
            logic m_full, acc;
            logic [FLUX-1:0] r;
            logic [WIDTH-1:0] d;
            int tg;
            d = WIDTH'($urandom);
            r[0] = ($urandom_range(0, 9) < 4);
            r[1] = ($urandom_range(0, 9) < 4);
            wr = ($urandom_range(0, 9) < 7); din = d; rd = r;
            m_full = 1'b0;
            for (int f = 0; f < FLUX; f++) if (mq[f].size() == DEPTH) m_full = 1'b1;
            acc = wr && !m_full;
            step();
            for (int f = 0; f < FLUX; f++)
                if (r[f] && mq[f].size() > 0) void'(mq[f].pop_front());
            if (acc) begin
                tg = int'(d[WIDTH-1]);
                mq[tg].push_back(d[DW-1:0]);
                acc_cnt[tg]++;
            end
            m_full = 1'b0;
            for (int f = 0; f < FLUX; f++) begin
                if (mq[f].size() == DEPTH) m_full = 1'b1;
                chk($sformatf("rnd%0d_e%0d", n, f), 32'(empty[f]), 32'(mq[f].size() == 0));
                if (mq[f].size() > 0)
                    chk($sformatf("rnd%0d_d%0d", n, f), 32'(d_of(f)), 32'(mq[f][0]));
            end
            chk($sformatf("rnd%0d_full", n), 32'(full), 32'(m_full));
        end
        wr = 1'b0; rd = '0;

`ifdef FLUX_DEMUX_STATS_EN
        for (int f = 0; f < FLUX; f++)
            chk($sformatf("stat_count%0d", f), 32'(stat_count[f*16 +: 16]), 32'(acc_cnt[f]));
        chk("stat_drop_none", 32'(stat_drop), 32'h0);

        do_reset();
        chk("stat3_reset", 32'(sd3), 32'h0);
        wr3 = 1'b1; din3 = {2'b11, 8'hEE};
        step();
        for (int i = 0; i < 5; i++) begin
            din3 = {2'(i % 3), 8'(i)};
            step();
        end
        wr3 = 1'b0;
        chk("stat3_drop", 32'(sd3), 32'h1);
        chk("stat3_sum", 32'(sc3[15:0]) + 32'(sc3[31:16]) + 32'(sc3[47:32]), 32'd5);
        chk("stat3_f0", 32'(sc3[15:0]), 32'd2);
        chk("stat3_f2", 32'(sc3[47:32]), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flux_demux_sink.md
FLUX_DEMUX_SINK -- requirements
Module: flux_demux_sink

Interface
- REQ-001 SHALL take parameter WIDTH, default 9: total token width, tag plus payload.
- REQ-002 SHALL take parameter FLUX, default 2: number of streams.
- REQ-003 SHALL take parameter DEPTH, default 4: per-flux FIFO depth in tokens, power of two, at least 2.
- REQ-004 SHALL derive TAG_WIDTH = $clog2(FLUX) (1 when FLUX=1) and DATA_WIDTH = WIDTH-TAG_WIDTH as localparams.
- REQ-005 clk  in  1  single clock; all state SHALL change on its rising edge.
- REQ-006 rst  in  1  asynchronous, active-high reset.
- REQ-007 in_port_write  in  1  upstream token valid/write strobe.
- REQ-008 in_port_datain  in  WIDTH  token; tag in bits [WIDTH-1 -: TAG_WIDTH], payload in [DATA_WIDTH-1:0].
- REQ-009 in_port_full  out  1  backpressure to upstream actor out_port_full.
- REQ-010 out_port_read  in  FLUX  per-flux pop strobe.
- REQ-011 out_port_dataout  out  FLUX*DATA_WIDTH  per-flux head payload, flux f at slice [f*DATA_WIDTH +: DATA_WIDTH].
- REQ-012 out_port_empty  out  FLUX  per-flux empty flag.

Function
- REQ-013 Token SHALL be accepted on a rising edge iff in_port_write=1 and in_port_full=0; otherwise it SHALL be ignored, with no state change.
- REQ-014 An accepted token SHALL have its tag stripped and its payload pushed into FIFO[tag].
- REQ-015 A tag >= FLUX SHALL drop the token, with no FIFO change.
- REQ-016 in_port_full SHALL equal the OR of all per-flux full flags, registered-count based, so that upstream stalls conservatively because it cannot know the next tag.
- REQ-017 Each FIFO SHALL be first-word fall-through: out_port_dataout slice shows the head whenever out_port_empty[f]=0, and its value is don't-care when empty.
- REQ-018 Write-to-visible latency SHALL be one cycle: empty[f] deasserts on the edge that writes the first token.
- REQ-019 Pop SHALL occur on an edge with out_port_read[f]=1 and out_port_empty[f]=0; a read while empty SHALL be ignored.
- REQ-020 Simultaneous push and pop on the same flux SHALL leave its count unchanged and keep data order.
- REQ-021 Pushes to one flux and pops from others in the same cycle SHALL be independent.
- REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; full[f] SHALL be (count==DEPTH).
- REQ-023 Per-flux ordering SHALL be strict FIFO; there is no ordering guarantee across fluxes.

Reset
- REQ-024 While rst=1, regardless of clock, all counts and pointers SHALL be 0, out_port_empty SHALL be all ones, and in_port_full SHALL be 0.
- REQ-025 Reset asserted mid-operation SHALL discard all buffered tokens; no write or read SHALL be accepted while rst=1.
- REQ-026 FIFO storage arrays SHALL NOT be reset.

Configuration
- REQ-027 With macro FLUX_DEMUX_STATS_EN defined, the block SHALL add an output stat_count of width FLUX*16, counting accepted tokens per flux, and an output stat_drop of width 16, counting REQ-015 drops.
- REQ-028 Both counters SHALL saturate at 16'hFFFF and reset to 0.
- REQ-029 Without FLUX_DEMUX_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
- REQ-030 Shared package flux_pkg SHALL hold the tag-width function (clog2 with a minimum of 1) and the tag/payload slicing helpers, reused by upstream wrappers.
- REQ-031 The block SHALL contain one sub-module, flux_fifo (parameters DATA_WIDTH and DEPTH; ports push, pop, din, dout, empty, full), instantiated FLUX times via generate.

Verification
- REQ-032 After reset, write {1'b1,8'd8} -> next cycle empty=2'b01, flux1 dout=8'd8, flux0 still empty.
- REQ-033 Write 4 tokens tagged 0 with no reads -> in_port_full=1 after the 4th; a 5th write {1'b0,8'd5} is ignored; pops return 1,2,3,4 in order.
- REQ-034 With flux0 holding 2 tokens, push and pop flux0 in the same cycle -> count stays 2 and order is preserved.
- REQ-035 Read strobe on an empty flux -> no change, empty stays 1, no pointer movement.
- REQ-036 Assert rst with 3 tokens buffered across fluxes -> immediately empty=all ones and full=0; post-reset writes behave as in REQ-032.
- REQ-037 Under FLUX_DEMUX_STATS_EN, with FLUX=3 and tag 2'b11 written once plus 5 valid tokens -> stat_drop=1 and the per-flux stat_count values sum to 5.
